mem_access_unit: RTL

- MEM-stage datapath/sequencer of the 5-stage 16-bit pipeline.
- Consumes the EX/MEM register contents and decodes LD/ST/STU from the opcode.
- Runs a request/done handshake against a multi-cycle data memory, stalls upstream while the access is in flight, and drives the MEM/WB pipeline register.

---
 rtl/mem_access_unit_pkg.sv | 27 ++
 rtl/mem_access_unit_wait_timer.sv | 41 ++++
 rtl/mem_access_unit.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_unit_pkg
// Shared definitions for the MEM stage of the 16-bit, 5-stage pipeline:
// opcode constants (also used by the MEM control decode), default widths,
// the MEM sequencer state encoding and a small opcode classification helper.
// Ports: none (package).
// -----------------------------------------------------------------------------
package mem_access_unit_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_REG_W  = 3;

  localparam logic [4:0] OP_HALT = 5'b00000;
  localparam logic [4:0] OP_ST   = 5'b10000;
  localparam logic [4:0] OP_LD   = 5'b10001;
  localparam logic [4:0] OP_STU  = 5'b10011;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mau_state_e;

  function automatic logic is_mem_op(input logic [4:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_STU);
  endfunction

endpackage

// File: rtl/mem_access_unit_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles spent waiting on the data memory and flags the cycle that is
// the MAX_WAIT-th waiting cycle.
// Ports:
//   clk        system clock
//   rst_n      synchronous active-low reset
//   i_clr      clear the count (request issue cycle)
//   i_en       count this cycle (memory access in flight)
//   o_at_limit current cycle is the MAX_WAIT-th counted cycle
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_at_limit
);

  localparam int         CNT_W = 8;
  // Count starts at 0 in the first waiting cycle, so the MAX_WAIT-th waiting
  // cycle sees MAX_WAIT-1.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_at_limit = (r_count == LIMIT);

endmodule

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// MEM stage of the 16-bit pipeline. Decodes LD/ST/STU from the EX/MEM
// register, issues a one-cycle request to a multi-cycle data memory, stalls
// upstream while the access is in flight, times out a memory that never
// answers, and drives the MEM/WB pipeline register.
//
// Build option: define MEM_ALIGN_CHECK_EN to reject memory ops whose address
// bit 0 is set (no request, retire without write, pulse err_align).
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   in_valid/in_opcode/...       EX/MEM register contents
//   stall_out                    hold EX/MEM upstream
//   mem_en/mem_wr/mem_addr/
//   mem_wdata                    memory request (mem_en is a 1-cycle strobe)
//   mem_rdata/mem_done           memory response
//   wb_valid/wb_data/wb_wr_en/
//   wb_reg/wb_halt               MEM/WB register
//   err_timeout                  1-cycle pulse when the memory timed out
//   err_align (option)           1-cycle pulse on a misaligned memory op
// -----------------------------------------------------------------------------
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int REG_W    = DEF_REG_W,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [4:0]        in_opcode,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic              in_wr_en,
  input  logic [REG_W-1:0]  in_wr_reg,
  output logic              stall_out,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_wr_en,
  output logic [REG_W-1:0]  wb_reg,
  output logic              wb_halt,
  output logic              err_timeout
`ifdef MEM_ALIGN_CHECK_EN
  ,
  output logic              err_align
`endif
);

  mau_state_e r_state;
  mau_state_e w_next_state;

  logic w_is_st, w_is_stu, w_is_ld, w_is_mem, w_is_halt;
  logic w_misalign, w_issue, w_done, w_timeout, w_at_limit, w_idle;

  // Request captured at issue; held while the access is in flight.
  logic [DATA_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wr;
  logic              r_is_ld;
  logic              r_is_st;
  logic              r_wr_en;
  logic [REG_W-1:0]  r_wr_reg;

  assign w_is_ld   = (in_opcode == OP_LD);
  assign w_is_st   = (in_opcode == OP_ST);
  assign w_is_stu  = (in_opcode == OP_STU);
  assign w_is_mem  = is_mem_op(in_opcode);
  assign w_is_halt = (in_opcode == OP_HALT);
  assign w_idle    = (r_state == ST_IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = in_alu_result[0];
`else
  assign w_misalign = 1'b0;
`endif

  assign w_issue   = w_idle & in_valid & w_is_mem & ~w_misalign;
  assign w_done    = (r_state == ST_BUSY) & mem_done;
  // mem_done takes priority over a timeout in the same cycle.
  assign w_timeout = (r_state == ST_BUSY) & ~mem_done & w_at_limit;

  mem_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_issue),
    .i_en       (r_state == ST_BUSY),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_issue)              w_next_state = ST_BUSY;
      ST_BUSY: if (w_done || w_timeout)  w_next_state = ST_IDLE;
      default:                           w_next_state = ST_IDLE;
    endcase
  end

  // Request and stall outputs are forced low while reset is asserted, even
  // if the state register has not yet been cleared by the reset edge.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    stall_out = 1'b0;
    mem_addr  = r_addr;
    mem_wdata = r_wdata;
    if (w_idle) begin
      mem_addr  = in_alu_result;
      mem_wdata = in_store_data;
      mem_en    = rst_n & w_issue;
      mem_wr    = rst_n & w_issue & (w_is_st | w_is_stu);
      stall_out = rst_n & w_issue;
    end else begin
      mem_wr    = rst_n & r_wr;
      stall_out = rst_n & ~mem_done & ~w_at_limit;
    end
  end

  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_addr   <= in_alu_result;
      r_wdata  <= in_store_data;
      r_wr     <= w_is_st | w_is_stu;
      r_is_ld  <= w_is_ld;
      r_is_st  <= w_is_st;
      r_wr_en  <= in_wr_en;
      r_wr_reg <= in_wr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_wr_en    <= 1'b0;
      wb_reg      <= '0;
      wb_halt     <= 1'b0;
      err_timeout <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      err_align   <= 1'b0;
`endif
    end else begin
      err_timeout <= w_timeout;
`ifdef MEM_ALIGN_CHECK_EN
      err_align   <= w_idle & in_valid & w_is_mem & w_misalign;
`endif
      if (w_idle) begin
        // Non-memory ops retire here; a misaligned memory op retires with no
        // write; an issued memory op leaves a bubble until it completes.
        wb_valid <= in_valid & ~w_issue;
        wb_data  <= in_alu_result;
        wb_wr_en <= in_valid & ~w_is_mem & in_wr_en;
        wb_reg   <= in_wr_reg;
        wb_halt  <= in_valid & w_is_halt;
      end else begin
        wb_halt <= 1'b0;
        wb_reg  <= r_wr_reg;
        if (w_done) begin
          wb_valid <= 1'b1;
          wb_data  <= r_is_ld ? mem_rdata : r_addr;
          wb_wr_en <= r_wr_en & ~r_is_st;
        end else if (w_timeout) begin
          wb_valid <= 1'b1;
          wb_data  <= r_addr;
          wb_wr_en <= 1'b0;
        end else begin
          wb_valid <= 1'b0;
          wb_wr_en <= 1'b0;
        end
      end
    end
  end

endmodule
